// File: rtl/mesh_term_rx_if.sv
// Router-terminal pending/pop handshake plus local FIFO consumer port for mesh_term_rx.
// master = environment (router + consumer), slave = the receive endpoint.
interface mesh_term_rx_if #(
  parameter int pckg_sz   = 40,
  parameter int deep_fifo = 8
);
  logic                       pndng_in;
  logic [pckg_sz-1:0]         data_in;
  logic                       pop;
  logic                       pndng_out;
  logic [pckg_sz-1:0]         data_out;
  logic                       pop_out;
  logic                       full;
  logic [$clog2(deep_fifo):0] count;
  logic [15:0]                rx_cnt;
  logic [15:0]                drop_cnt;

  modport master (
    output pndng_in, data_in, pop_out,
    input  pop, pndng_out, data_out, full, count, rx_cnt, drop_cnt
  );

  modport slave (
    input  pndng_in, data_in, pop_out,
    output pop, pndng_out, data_out, full, count, rx_cnt, drop_cnt
  );
endinterface

// File: rtl/mesh_term_rx.sv
// Mesh terminal receive endpoint: drains router packets into a fall-through FIFO with rx/drop counters.
// Define MESH_TERM_RX_ID_CHECK_EN to drop packets whose destination differs from (id_row, id_col).
module mesh_term_rx #(
  parameter int         pckg_sz   = 40,
  parameter int         deep_fifo = 8,
  parameter logic [3:0] id_row    = 4'd1,
  parameter logic [3:0] id_col    = 4'd1
) (
  input logic           clk,
  input logic           reset,
  mesh_term_rx_if.slave bus
);
  localparam int ptr_w = $clog2(deep_fifo);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(deep_fifo);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state_r;
  logic               pop_r;
  logic [pckg_sz-1:0] mem_r [deep_fifo];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               full_r;
  logic               pndng_out_r;
  logic [15:0]        rx_cnt_r;
  logic               accept_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic [cnt_w-1:0]   count_nxt_s;

`ifdef MESH_TERM_RX_ID_CHECK_EN
  logic [3:0]  dest_row_s;
  logic [3:0]  dest_col_s;
  logic [15:0] drop_cnt_r;

  // Destination match against this terminal's address
  always_comb begin
    dest_row_s = bus.data_in[pckg_sz-9 -: 4];
    dest_col_s = bus.data_in[pckg_sz-13 -: 4];
    if ((dest_row_s == id_row) && (dest_col_s == id_col)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Misrouted packet counter, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= 16'h0000;
    end else if ((state_r == POP) && !accept_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.drop_cnt = drop_cnt_r;
`else
  assign accept_s     = 1'b1;
  assign bus.drop_cnt = 16'h0000;
`endif

  // Write/read enables and next occupancy
  always_comb begin
    wr_en_s = 1'b0;
    if (state_r == POP) begin
      wr_en_s = accept_s;
    end else begin
      wr_en_s = 1'b0;
    end
    rd_en_s = bus.pop_out & pndng_out_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + cnt_w'(1'b1);
      2'b01:   count_nxt_s = count_r - cnt_w'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Ingress FSM; pop is a registered decode of entering POP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      pop_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.pndng_in && (count_r < depth_c)) begin
            state_r <= POP;
            pop_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            pop_r   <= 1'b0;
          end
        end
        POP: begin
          state_r <= SETTLE;
          pop_r   <= 1'b0;
        end
        SETTLE: begin
          state_r <= IDLE;
          pop_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          pop_r   <= 1'b0;
        end
      endcase
    end
  end

  // Pointers, occupancy flags and accepted-packet counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {ptr_w{1'b0}};
      rd_ptr_r    <= {ptr_w{1'b0}};
      count_r     <= {cnt_w{1'b0}};
      full_r      <= 1'b0;
      pndng_out_r <= 1'b0;
      rx_cnt_r    <= 16'h0000;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1'b1);
        rx_cnt_r <= rx_cnt_r + 16'h0001;
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rx_cnt_r <= rx_cnt_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == depth_c);
      pndng_out_r <= (count_nxt_s != {cnt_w{1'b0}});
    end
  end

  // Packet storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  assign bus.pop       = pop_r;
  assign bus.pndng_out = pndng_out_r;
  assign bus.data_out  = mem_r[rd_ptr_r];
  assign bus.full      = full_r;
  assign bus.count     = count_r;
  assign bus.rx_cnt    = rx_cnt_r;
endmodule
